// File: rtl/dcache_line_responder_if.sv
// Purpose: bundles the D-side request/response port and the line-wide
//          physical memory port of dcache_line_responder.
// Signals:
//   mem_*  : 16-bit word/byte request from the datapath and its response
//   pmem_* : 128-bit line fill / writeback port toward physical memory
// Modports:
//   slave  : the responder (cache) side
//   master : the requester + physical memory side (datapath / arbiter / bench)
interface dcache_line_responder_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic         indirect;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, indirect,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, indirect,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/dcache_line_responder.sv
// Purpose: direct-mapped, write-back data cache of 128-bit lines answering
//          16-bit word/byte requests. Hits respond in the same cycle; misses
//          optionally write back a dirty victim, then fill the line, then
//          hit on return to IDLE.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dcache_line_responder_if.slave (mem_* request side, pmem_* line side)
// Parameters:
//   SETS    : number of lines, power of 2 in 2..32
module dcache_line_responder #(
    parameter int unsigned SETS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dcache_line_responder_if.slave  bus
);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAGW  = 12 - IDX;
    localparam int unsigned LINEW = 128;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t            state_q;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAGW-1:0]   tag_q  [SETS];
    logic [LINEW-1:0]  data_q [SETS];
    logic [11:0]       req_line_q;
    logic [15:0]       pmem_addr_q;
    logic [LINEW-1:0]  pmem_wdata_q;

    logic [IDX-1:0]    idx_c;
    logic [TAGW-1:0]   tag_c;
    logic [2:0]        word_c;
    logic [IDX-1:0]    fill_idx_c;
    logic [TAGW-1:0]   fill_tag_c;
    logic              req_c;
    logic              hit_c;
    logic              resp_c;
    logic              wr_hit_c;
    logic [15:0]       rd_word_c;
    logic              unused_c;

    // Request decode and hit detection
    always_comb begin
        idx_c      = bus.mem_address[4 +: IDX];
        tag_c      = bus.mem_address[15 -: TAGW];
        word_c     = bus.mem_address[3:1];
        fill_idx_c = req_line_q[IDX-1:0];
        fill_tag_c = req_line_q[11 -: TAGW];
        req_c      = bus.mem_read | bus.mem_write;
        hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
        resp_c     = (state_q == IDLE) && req_c && hit_c;
        // A simultaneous read+write is serviced as a write
        wr_hit_c   = resp_c && bus.mem_write;
        rd_word_c  = data_q[idx_c][{word_c, 4'h0} +: 16];
    end

    // indirect and byte-address bit 0 carry no function here
    assign unused_c = ^{bus.indirect, bus.mem_address[0]};

    assign bus.mem_resp     = resp_c;
    assign bus.mem_rdata    = (resp_c && !bus.mem_write) ? rd_word_c : 16'h0000;
    assign bus.pmem_read    = (state_q == FILL);
    assign bus.pmem_write   = (state_q == WRITEBACK);
    assign bus.pmem_address = pmem_addr_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

    // Miss FSM, line status bits and the registered pmem transfer payload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            req_line_q   <= 12'h000;
            pmem_addr_q  <= 16'h0000;
            pmem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_hit_c) begin
                        dirty_q[idx_c] <= 1'b1;
                    end else if (req_c && !hit_c) begin
                        req_line_q <= bus.mem_address[15:4];
                        if (valid_q[idx_c] && dirty_q[idx_c]) begin
                            state_q      <= WRITEBACK;
                            pmem_addr_q  <= {tag_q[idx_c], idx_c, 4'h0};
                            pmem_wdata_q <= data_q[idx_c];
                        end else begin
                            state_q     <= FILL;
                            pmem_addr_q <= {bus.mem_address[15:4], 4'h0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[fill_idx_c] <= 1'b0;
                        state_q             <= FILL;
                        pmem_addr_q         <= {req_line_q, 4'h0};
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        valid_q[fill_idx_c] <= 1'b1;
                        dirty_q[fill_idx_c] <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays; contents need no reset because valid gates them
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && bus.pmem_resp) begin
            data_q[fill_idx_c] <= bus.pmem_rdata;
            tag_q[fill_idx_c]  <= fill_tag_c;
        end else if (wr_hit_c) begin
            if (bus.mem_byte_enable[0]) begin
                data_q[idx_c][{word_c, 4'h0} +: 8] <= bus.mem_wdata[7:0];
            end
            if (bus.mem_byte_enable[1]) begin
                data_q[idx_c][{word_c, 4'h8} +: 8] <= bus.mem_wdata[15:8];
            end
        end
    end
endmodule

// File: tb/tb_dcache_line_responder.sv
// Purpose: self-checking bench for dcache_line_responder (SETS=8). Acts as
//          requester and as a line-wide physical memory with programmable
//          response latency. Expected read data comes from a flat word-level
//          reference memory; expectations are queued at issue and compared
//          when mem_resp is observed.
module tb_dcache_line_responder;
    logic clk = 1'b0;
    logic reset_n;

    dcache_line_responder_if bus ();

    dcache_line_responder #(.SETS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [15:0] addr;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } xfer_t;

    exp_t        sb [$];
    xfer_t       plog [$];
    logic [15:0] ref_mem [int];
    logic [15:0] bk_mem  [int];
    int          n_chk = 0;
    int          n_fail = 0;
    int          pmem_lat = 0;
    int          wcnt = 0;
    logic [15:0] t_addr;
    logic [15:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input int k);
        return 16'((k * 40503) ^ 23130);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        int k = int'(a[15:1]);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [15:0] bk_rd(input logic [15:0] a);
        int k = int'(a[15:1]);
        return bk_mem.exists(k) ? bk_mem[k] : init_word(k);
    endfunction

    function automatic logic [127:0] bk_line(input logic [15:0] a);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[16*w +: 16] = bk_rd({a[15:4], 3'(w), 1'b0});
        return l;
    endfunction

    // Physical memory: responds pmem_lat cycles after a strobe appears
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (!(bus.pmem_read || bus.pmem_write)) begin
                wcnt = 0;
            end else begin
                if (wcnt == 0) t_addr = bus.pmem_address;
                else check_eq("pmem_addr_stable", 32'(bus.pmem_address), 32'(t_addr));
                if (wcnt >= pmem_lat) begin
                    if (bus.pmem_write) begin
                        for (int w = 0; w < 8; w++) begin
                            check_eq("wb_word", 32'(bus.pmem_wdata[16*w +: 16]),
                                     32'(ref_rd({bus.pmem_address[15:4], 3'(w), 1'b0})));
                            bk_mem[int'({bus.pmem_address[15:4], 3'(w)})] = bus.pmem_wdata[16*w +: 16];
                        end
                        plog.push_back('{1'b1, bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = bk_line(bus.pmem_address);
                        plog.push_back('{1'b0, bus.pmem_address, bus.pmem_rdata});
                    end
                    bus.pmem_resp = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Issue one request, wait (bounded) for mem_resp, score it; lat counts cycles
    task automatic do_req(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd, output int lat);
        exp_t e;
        logic got;
        logic [15:0] w;
        sb.push_back('{rd & ~wr, a, ref_rd(a)});
        bus.mem_address     = a;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            got = bus.mem_resp;
            if (!got) @(posedge clk);
        end
        e = sb.pop_front();
        if (!got) begin
            check_eq("resp_timeout", 32'(0), 32'(1));
        end else if (e.is_read) begin
            last_rd = bus.mem_rdata;
            check_eq("rdata", 32'(bus.mem_rdata), 32'(e.rdata));
        end else begin
            w = ref_rd(a);
            if (be[0]) w[7:0]  = wd[7:0];
            if (be[1]) w[15:8] = wd[15:8];
            ref_mem[int'(a[15:1])] = w;
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int r;
        logic [15:0] a;
        reset_n             = 1'b0;
        bus.mem_address     = 16'h0000;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_wdata       = 16'h0000;
        bus.indirect        = 1'b0;
        last_rd             = 16'h0000;
        bk_mem[int'(16'h0023)]  = 16'hBEEF;
        ref_mem[int'(16'h0023)] = 16'hBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_resp",  32'(bus.mem_resp), 32'(0));
        check_eq("rst_pmem_read", 32'(bus.pmem_read), 32'(0));
        check_eq("rst_pmem_write", 32'(bus.pmem_write), 32'(0));
        check_eq("rst_pmem_addr", 32'(bus.pmem_address), 32'(0));
        check_eq("rst_pmem_wdata", 32'(|bus.pmem_wdata), 32'(0));
        check_eq("rst_mem_rdata", 32'(bus.mem_rdata), 32'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss, fill from 0x0040
        plog.delete();
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("cold_lat", 32'(lat), 32'(3));
        check_eq("cold_xfers", 32'(plog.size()), 32'(1));
        if (plog.size() >= 1) begin
            check_eq("cold_is_fill", 32'(plog[0].wr), 32'(0));
            check_eq("cold_fill_addr", 32'(plog[0].addr), 32'h0040);
        end
        check_eq("cold_rdata", 32'(last_rd), 32'hBEEF);

        // Read hit in the same line
        plog.delete();
        do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("hit_lat", 32'(lat), 32'(1));
        check_eq("hit_no_pmem", 32'(plog.size()), 32'(0));

        // Low-byte write then read-back, back to back
        do_req(16'h0046, 1'b0, 1'b1, 2'b01, 16'h12AB, lat);
        check_eq("wr_hit_lat", 32'(lat), 32'(1));
        do_req(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("wr_merge_rd", 32'(last_rd), 32'hBEAB);

        // Conflict miss with dirty victim: writeback then fill
        plog.delete();
        do_req(16'h0846, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("conflict_lat", 32'(lat), 32'(4));
        check_eq("conflict_xfers", 32'(plog.size()), 32'(2));
        if (plog.size() >= 2) begin
            check_eq("conflict_wb", 32'(plog[0].wr), 32'(1));
            check_eq("conflict_wb_addr", 32'(plog[0].addr), 32'h0040);
            check_eq("conflict_wb_w3", 32'(plog[0].data[63:48]), 32'hBEAB);
            check_eq("conflict_fill", 32'(plog[1].wr), 32'(0));
            check_eq("conflict_fill_addr", 32'(plog[1].addr), 32'h0840);
        end

        // Reset asserted in the middle of a slow fill
        pmem_lat            = 5;
        bus.mem_address     = 16'h0086;
        bus.mem_read        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("fill_strobe", 32'(bus.pmem_read), 32'(1));
        reset_n = 1'b0;
        #1;
        check_eq("rst_fill_read", 32'(bus.pmem_read), 32'(0));
        check_eq("rst_fill_write", 32'(bus.pmem_write), 32'(0));
        check_eq("rst_fill_resp", 32'(bus.mem_resp), 32'(0));
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        pmem_lat = 0;
        @(posedge clk);
        #1;
        plog.delete();
        do_req(16'h0086, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("post_rst_lat", 32'(lat), 32'(3));
        check_eq("post_rst_xfers", 32'(plog.size()), 32'(1));

        // Read+write together is a write, and marks the line dirty
        do_req(16'h0086, 1'b1, 1'b1, 2'b11, 16'h5555, lat);
        check_eq("rw_lat", 32'(lat), 32'(1));
        do_req(16'h0086, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("rw_rd", 32'(last_rd), 32'h5555);
        plog.delete();
        do_req(16'h0886, 1'b1, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("rw_dirty_lat", 32'(lat), 32'(4));
        if (plog.size() >= 1) begin
            check_eq("rw_wb", 32'(plog[0].wr), 32'(1));
            check_eq("rw_wb_addr", 32'(plog[0].addr), 32'h0080);
            check_eq("rw_wb_w3", 32'(plog[0].data[63:48]), 32'h5555);
        end else begin
            check_eq("rw_wb_missing", 32'(plog.size()), 32'(1));
        end

        // Random traffic over a few tags per set with varying pmem latency
        for (int i = 0; i < 300; i++) begin
            pmem_lat = $urandom_range(0, 3);
            a = 16'($urandom_range(0, 3) << 7) | 16'($urandom_range(0, 7) << 4)
              | 16'($urandom_range(0, 7) << 1);
            r = $urandom_range(0, 2);
            do_req(a, (r != 1), (r != 0), 2'($urandom_range(0, 3)), 16'($urandom), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
